// File: rtl/insn_fetch_pkg.sv
// Shared fetch-stage types and constants: queue entry layout, default reset IP, injected INT opcode.
// Imported by the fetch top and its prefetch queue.
package insn_fetch_pkg;

  localparam logic [15:0] INSN_INT      = 16'h7810;
  localparam logic [15:0] RESET_IP_DFLT = 16'h0000;

  typedef struct packed {
    logic [15:0] insn;
    logic [15:0] ip;
  } fq_entry_t;

  // Instruction addresses are halfword aligned; bit0 is never meaningful.
  function automatic logic [15:0] align_ip(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction

endpackage

// File: rtl/insn_fetch_queue.sv
// Prefetch FIFO of {insn, ip}: pushed entry visible at head next cycle, push+pop same cycle allowed.
// No internal backpressure; the caller never pushes when full or pops when empty; flush wins.
module insn_fetch_queue
  import insn_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fq_entry_t                push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTRW = $clog2(DEPTH);

  fq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTRW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PTRW:0]         cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_dat;
        tail_d        = tail_q + PTRW'(1);
      end
      if (pop) begin
        head_d = head_q + PTRW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + (PTRW+1)'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - (PTRW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head_dat = mem_q[head_q];
    count    = cnt_q;
    empty    = (cnt_q == '0);
  end

endmodule

// File: rtl/insn_fetch.sv
// Fetch stage: one outstanding memory read, prefetch queue, redirect flush, INT injection; insn valid 2 cycles after gnt.
// Stops issuing when the queue (including the in-flight word) is full; output held stable until insn_ready or redirect.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int          QDEPTH   = 2,
  parameter logic [15:0] RESET_IP = RESET_IP_DFLT,
  parameter logic [15:0] INT_INSN = INSN_INT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [15:0] insn,
  output logic [15:0] insn_ip,
  input  logic        redirect,
  input  logic [15:0] new_ip,
  input  logic        irq,
  input  logic        ien,
  output logic        irq_ack
);

  localparam int            PTRW    = $clog2(QDEPTH);
  localparam logic [PTRW:0] CNT_MAX = (PTRW+1)'(QDEPTH);

  logic [15:0]   pc_q, pc_d, req_ip_q, req_ip_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic          int_sel_q, int_sel_d;
  logic          issue_vld, rsp_vld, acc_vld, push, pop;
  fq_entry_t     push_dat, head_dat;
  logic [PTRW:0] q_count;
  logic          q_empty;

  insn_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .count    (q_count),
    .empty    (q_empty)
  );

  always_comb begin
    mem_req    = !rst && !redirect && !outstanding_q && (q_count < CNT_MAX);
    mem_addr   = pc_q;
    issue_vld  = mem_req && mem_gnt;
    // A response with nothing outstanding belongs to a request killed by reset.
    rsp_vld    = mem_rvalid && outstanding_q;

    insn_valid = !q_empty;
    insn       = insn_valid ? (int_sel_q ? INT_INSN : head_dat.insn) : '0;
    insn_ip    = insn_valid ? head_dat.ip : '0;
    acc_vld    = insn_valid && insn_ready && !redirect;
    pop        = acc_vld && !int_sel_q;
    irq_ack    = acc_vld && int_sel_q;

    push          = rsp_vld && !drop_q && !redirect;
    push_dat.insn = mem_rdata;
    push_dat.ip   = req_ip_q;

    pc_d          = pc_q;
    req_ip_d      = req_ip_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    int_sel_d     = int_sel_q;

    if (rsp_vld) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (issue_vld) begin
      pc_d          = pc_q + 16'd2;
      req_ip_d      = pc_q;
      outstanding_d = 1'b1;
    end

    if (redirect) begin
      pc_d      = align_ip(new_ip);
      int_sel_d = 1'b0;
      drop_d    = outstanding_q && !mem_rvalid;
    end else if (irq_ack) begin
      int_sel_d = 1'b0;
    end else if (!int_sel_q && irq && ien && !(insn_valid && !insn_ready)) begin
      // Only arm while the output is free, so a presented insn never changes under the decoder.
      int_sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= align_ip(RESET_IP);
      req_ip_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      int_sel_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_ip_q      <= req_ip_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      int_sel_q     <= int_sel_d;
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: memory responder with programmable latency, stream-level reference model, directed tests.
module tb_insn_fetch;
  import insn_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        insn_valid;
  logic        insn_ready;
  logic [15:0] insn;
  logic [15:0] insn_ip;
  logic        redirect;
  logic [15:0] new_ip;
  logic        irq;
  logic        ien;
  logic        irq_ack;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit rand_gnt = 1'b0;

  logic [15:0] iss_q[$];
  logic [15:0] got_insn[$];
  logic [15:0] got_ip[$];
  int          ack_cnt;

  logic [15:0] model_pc, model_ip, p_insn, p_ip;
  logic        armed, prev_stall, prev_redir, acc_c;

  insn_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .insn       (insn),
    .insn_ip    (insn_ip),
    .redirect   (redirect),
    .new_ip     (new_ip),
    .irq        (irq),
    .ien        (ien),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: word at byte address a.
  function automatic logic [15:0] mem_img(input logic [15:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'h0101 + 32'h8005;
    return p[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Memory responder: in-order, one request in flight, latency drawn from [lat_min, lat_max].
  initial begin
    bit          pend;
    logic [15:0] paddr;
    int          wcnt;
    pend = 1'b0; paddr = '0; wcnt = 0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (pend) begin
        if (wcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_img(paddr);
          pend       = 1'b0;
        end else begin
          wcnt--;
        end
      end
      mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst) pend = 1'b0;
      else if (mem_req && mem_gnt) begin
        pend  = 1'b1;
        paddr = mem_addr;
        wcnt  = int'($urandom_range(lat_min, lat_max)) - 1;
      end
    end
  end

  // Stream model: fetch addresses and delivered instructions follow pc/ip sequences
  // restarted by reset and redirect; INT appears only after irq&&ien and never consumes an entry.
  always @(negedge clk) begin
    if (rst) begin
      chk("req_in_reset", mem_req, 1'b0);
      model_pc   = RESET_IP_DFLT;
      model_ip   = RESET_IP_DFLT;
      armed      = 1'b0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      ack_cnt    = 0;
      iss_q.delete();
      got_insn.delete();
      got_ip.delete();
    end else begin
      if (prev_redir) chk("valid_after_redirect", insn_valid, 1'b0);
      if (prev_stall) begin
        chk("hold_valid", insn_valid, 1'b1);
        chk("hold_insn", insn, p_insn);
        chk("hold_ip", insn_ip, p_ip);
      end
      if (mem_req) chk("fetch_addr", mem_addr, model_pc);
      if (mem_req && mem_gnt) begin
        iss_q.push_back(mem_addr);
        model_pc = model_pc + 16'd2;
      end
      acc_c = insn_valid && insn_ready && !redirect;
      if (insn_valid) begin
        chk("insn_ip", insn_ip, model_ip);
        if (insn == INSN_INT) chk("int_allowed", armed, 1'b1);
        else chk("insn_word", insn, mem_img(model_ip));
      end
      chk("irq_ack", irq_ack, acc_c && (insn == INSN_INT));
      if (acc_c) begin
        got_insn.push_back(insn);
        got_ip.push_back(insn_ip);
        if (insn == INSN_INT) begin
          armed = 1'b0;
          ack_cnt++;
        end else begin
          model_ip = model_ip + 16'd2;
        end
      end
      prev_stall = insn_valid && !insn_ready && !redirect;
      p_insn     = insn;
      p_ip       = insn_ip;
      prev_redir = redirect;
      if (redirect) begin
        model_pc = new_ip & 16'hFFFE;
        model_ip = new_ip & 16'hFFFE;
        armed    = 1'b0;
      end else if (irq && ien) begin
        armed = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = mem_req && mem_gnt;
    end
    if (!hit) chk({tag, "_issue_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    int          c_iss, c_val;
    bit          hit;
    logic [15:0] h;

    rst = 1'b1; insn_ready = 1'b1; redirect = 1'b0; new_ip = '0; irq = 1'b0; ien = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_insn_valid", insn_valid, 1'b0);
    chk("rst_insn", insn, 16'h0000);
    chk("rst_insn_ip", insn_ip, 16'h0000);
    chk("rst_irq_ack", irq_ack, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);

    // 1: first fetch latency and address sequence
    step(); rst = 1'b0;
    wait_issue("t1");
    c_iss = cyc;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (i != 0) @(negedge clk);
      hit = insn_valid;
    end
    c_val = cyc;
    chk("t1_valid_found", hit, 1'b1);
    chk("t1_latency", c_val - c_iss, 2);
    chk("t1_first_insn", insn, 16'h8005);
    chk("t1_first_ip", insn_ip, 16'h0000);
    repeat (8) step();
    @(negedge clk);
    chk("t1_addr0", iss_q[0], 16'h0000);
    chk("t1_addr1", iss_q[1], 16'h0002);
    chk("t1_addr2", iss_q[2], 16'h0004);
    chk("t1_got1_insn", got_insn[1], 16'h8207);
    chk("t1_got1_ip", got_ip[1], 16'h0002);

    // 2: decoder stalled, queue fills to depth and fetch stops
    insn_ready = 1'b0;
    step(); do_reset();
    repeat (10) step();
    @(negedge clk);
    chk("t2_fetch_count", iss_q.size(), 2);
    chk("t2_req_off", mem_req, 1'b0);
    chk("t2_head_insn", insn, 16'h8005);
    chk("t2_head_ip", insn_ip, 16'h0000);
    step(); insn_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("t2_pop0_ip", got_ip[0], 16'h0000);
    chk("t2_pop1_ip", got_ip[1], 16'h0002);
    chk("t2_resume_addr", iss_q[2], 16'h0004);

    // 3: redirect while a request is in flight; late data is dropped
    lat_min = 3; lat_max = 3;
    step(); do_reset();
    wait_issue("t3");
    step(); redirect = 1'b1; new_ip = 16'h0101;
    step(); redirect = 1'b0;
    repeat (12) step();
    @(negedge clk);
    chk("t3_addr_after", iss_q[1], 16'h0100);
    chk("t3_first_ip", got_ip[0], 16'h0100);
    chk("t3_first_insn", got_insn[0], 16'h8105);

    // 4: redirect in the same cycle as the response
    lat_min = 1; lat_max = 1;
    step(); do_reset();
    wait_issue("t4");
    step(); redirect = 1'b1; new_ip = 16'h0200;
    step(); redirect = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("t4_addr_after", iss_q[1], 16'h0200);
    chk("t4_first_ip", got_ip[0], 16'h0200);
    chk("t4_first_insn", got_insn[0], 16'h8205);

    // 5a: interrupt injected at head ip 0x0040, survives irq drop, head not popped
    insn_ready = 1'b0; ien = 1'b1;
    step(); do_reset();
    step(); redirect = 1'b1; new_ip = 16'h0040; irq = 1'b1;
    step(); redirect = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("t5_int_insn", insn, 16'h7810);
    chk("t5_int_ip", insn_ip, 16'h0040);
    chk("t5_no_ack_stalled", irq_ack, 1'b0);
    step(); irq = 1'b0;
    step();
    @(negedge clk);
    chk("t5_int_kept", insn, 16'h7810);
    step(); insn_ready = 1'b1;
    @(negedge clk);
    chk("t5_ack_pulse", irq_ack, 1'b1);
    step(); insn_ready = 1'b0;
    @(negedge clk);
    chk("t5_head_back", insn, 16'hC045);
    chk("t5_head_ip", insn_ip, 16'h0040);
    chk("t5_ack_gone", irq_ack, 1'b0);

    // 5b: interrupts disabled
    step(); ien = 1'b0; irq = 1'b1; insn_ready = 1'b1;
    repeat (8) step();
    insn_ready = 1'b0; irq = 1'b0;
    @(negedge clk);
    chk("t5_ack_count", ack_cnt, 1);
    chk("t5_got0", got_insn[0], 16'h7810);
    chk("t5_got1", got_insn[1], 16'hC045);
    chk("t5_got1_ip", got_ip[1], 16'h0040);
    chk("t5_got2_ip", got_ip[2], 16'h0042);

    // 5c: irq raised while output stalled is injected only after that insn is accepted
    repeat (4) step();
    irq = 1'b1; ien = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("t5c_valid", insn_valid, 1'b1);
    chk("t5c_not_int", insn == INSN_INT, 1'b0);
    chk("t5c_no_ack", irq_ack, 1'b0);
    h = insn_ip;
    step(); insn_ready = 1'b1;
    step(); insn_ready = 1'b0; irq = 1'b0;
    @(negedge clk);
    chk("t5c_int_now", insn, 16'h7810);
    chk("t5c_int_ip", insn_ip, h + 16'd2);
    step(); insn_ready = 1'b1;
    @(negedge clk);
    chk("t5c_ack", irq_ack, 1'b1);
    step(); insn_ready = 1'b1; ien = 1'b0;

    // 6: address wrap, then random grant and latency against the model
    step(); do_reset();
    step(); redirect = 1'b1; new_ip = 16'hFFFC;
    step(); redirect = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("t6_addr_fffc", iss_q[1], 16'hFFFC);
    chk("t6_addr_fffe", iss_q[2], 16'hFFFE);
    chk("t6_addr_wrap", iss_q[3], 16'h0000);
    chk("t6_got0_insn", got_insn[0], 16'h7C01);
    chk("t6_got2_ip", got_ip[2], 16'h0000);
    rand_gnt = 1'b1; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 400; i++) begin
      step();
      insn_ready = 1'($urandom_range(0, 1));
      redirect   = (i % 97 == 50);
      new_ip     = 16'($urandom);
    end
    step(); redirect = 1'b0; insn_ready = 1'b1; rand_gnt = 1'b0;
    repeat (20) step();
    @(negedge clk);
    chk("t6_progress", got_insn.size() >= 30, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not complete");
  end

endmodule
